// File: rtl/enable_table_loader_if.sv
// Byte-stream and table-write signals of the enable-table loader.
interface enable_table_loader_if #(
    parameter int unsigned ENTRY_BITS = 2,
    parameter int unsigned ADDR_BITS  = 9
);
    logic                  start;
    logic                  abort;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  table_we;
    logic [ENTRY_BITS-1:0] table_val;
    logic [ADDR_BITS-1:0]  table_write_addr;
    logic                  busy;
    logic                  done;
    logic                  error;

    // Byte source and load controller side
    modport master (
        output start,
        output abort,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  table_we,
        input  table_val,
        input  table_write_addr,
        input  busy,
        input  done,
        input  error
    );

    // Loader side
    modport slave (
        input  start,
        input  abort,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output table_we,
        output table_val,
        output table_write_addr,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/enable_table_loader.sv
// Enable-table loader: unpacks a stream of bytes into consecutive table
// entries (most significant field first), then checks a trailing
// mod-256 checksum byte. All outputs come straight from flops.
module enable_table_loader #(
    parameter int unsigned NUM_ENTRIES = 512,
    parameter int unsigned ENTRY_BITS  = 2,
    parameter int unsigned ADDR_BITS   = 9
) (
    input logic                  fpga_clk,
    input logic                  reset_n,
    enable_table_loader_if.slave bus
);

    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned FIELDS    = BYTE_BITS / ENTRY_BITS;
    localparam int unsigned CNT_BITS  = (FIELDS > 1) ? $clog2(FIELDS) : 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_ENTRIES - 1);
    localparam logic [CNT_BITS-1:0]  LAST_FIELD = CNT_BITS'(FIELDS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_BYTE = 3'd1,
        WRITE    = 3'd2,
        GET_SUM  = 3'd3,
        FINISH   = 3'd4
    } state_e;

    state_e                state_q,      state_d;
    logic [BYTE_BITS-1:0]  shift_q,      shift_d;
    logic [CNT_BITS-1:0]   cnt_q,        cnt_d;
    logic [BYTE_BITS-1:0]  acc_q,        acc_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  table_we_q,   table_we_d;
    logic [ENTRY_BITS-1:0] table_val_q,  table_val_d;
    logic [ADDR_BITS-1:0]  addr_q,       addr_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;

    logic handshake;
    logic last_addr;

    // Byte transfer happens only when the registered ready is already high
    assign handshake = bus.byte_valid && byte_ready_q;
    assign last_addr = (addr_q == LAST_ADDR);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        table_val_d  = table_val_q;
        addr_d       = addr_q;
        error_d      = error_q;
        table_we_d   = 1'b0;
        done_d       = 1'b0;
        byte_ready_d = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = '0;
                    acc_d   = '0;
                    error_d = 1'b0;
                    state_d = GET_BYTE;
                end
            end

            GET_BYTE: begin
                if (handshake) begin
                    acc_d       = acc_q + bus.byte_data;
                    table_val_d = bus.byte_data[BYTE_BITS-1 -: ENTRY_BITS];
                    shift_d     = bus.byte_data << ENTRY_BITS;
                    cnt_d       = '0;
                    table_we_d  = 1'b1;
                    state_d     = WRITE;
                end
            end

            WRITE: begin
                // The entry on the bus this cycle is written; step past it
                addr_d = last_addr ? '0 : addr_q + ADDR_BITS'(1);
                if (cnt_q == LAST_FIELD) begin
                    state_d = last_addr ? GET_SUM : GET_BYTE;
                end else begin
                    cnt_d       = cnt_q + CNT_BITS'(1);
                    table_val_d = shift_q[BYTE_BITS-1 -: ENTRY_BITS];
                    shift_d     = shift_q << ENTRY_BITS;
                    table_we_d  = 1'b1;
                end
            end

            GET_SUM: begin
                if (handshake) begin
                    // Table contents stay as written even on a mismatch
                    if (bus.byte_data != acc_q) begin
                        error_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort outranks everything, including a simultaneous start
        if (bus.abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            table_we_d = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b1;
        end

        byte_ready_d = (state_d == GET_BYTE) || (state_d == GET_SUM);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            byte_ready_q <= 1'b0;
            table_we_q   <= 1'b0;
            table_val_q  <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            byte_ready_q <= byte_ready_d;
            table_we_q   <= table_we_d;
            table_val_q  <= table_val_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.byte_ready       = byte_ready_q;
    assign bus.table_we         = table_we_q;
    assign bus.table_val        = table_val_q;
    assign bus.table_write_addr = addr_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;

endmodule

// File: tb/tb_enable_table_loader.sv
// Scoreboard bench for enable_table_loader: the stimulus side predicts
// every table write and done pulse, a negedge monitor checks them.
module tb_enable_table_loader;

    logic fpga_clk = 1'b0;
    logic reset_n;

    enable_table_loader_if bus ();

    enable_table_loader dut (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Edge counter: value read between edges N and N+1 is N
    longint cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int     addr;
        int     val;
        longint at;
    } wr_t;

    typedef struct {
        logic   err;
        longint at;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int         load_bytes;
    logic [7:0] sum_model;
    logic [7:0] load_data [128];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: every strobe and done pulse must match the oldest prediction
    always @(negedge fpga_clk) begin
        if (!reset_n) begin
            check("no_write_in_reset", bus.table_we, 1'b0);
        end else begin
            if (bus.table_we) begin
                check("ready_low_during_write", bus.byte_ready, 1'b0);
                if (exp_wr.size() == 0) begin
                    fail_now($sformatf("unexpected_write addr=%0d val=%0d", bus.table_write_addr, bus.table_val));
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", 64'(bus.table_write_addr), 64'(w.addr));
                    check("write_val",  64'(bus.table_val), 64'(w.val));
                    check("write_cycle", 64'(cyc), 64'(w.at));
                end
            end
            if (bus.done) begin
                if (exp_dn.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    dn_t d;
                    d = exp_dn.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.at));
                    check("error_at_done", 64'(bus.error), 64'(d.err));
                end
            end
        end
    end

    // Drop predictions for writes that can no longer happen after cycle lim
    task automatic prune_after(input longint lim);
        while (exp_wr.size() > 0 && exp_wr[$].at > lim) begin
            void'(exp_wr.pop_back());
        end
    endtask

    // Entered and left on a negedge; predicts the effect of an accepted byte
    task automatic send_byte(input logic [7:0] b, input bit is_sum, output longint acc_at);
        bit got = 1'b0;
        bit r;
        acc_at = -1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; t < 200; t++) begin
            r = bus.byte_ready;
            @(posedge fpga_clk);
            #1;
            if (r) begin
                got    = 1'b1;
                acc_at = cyc;
                break;
            end
            @(negedge fpga_clk);
        end
        if (got) begin
            if (is_sum) begin
                dn_t d;
                d.err = (b != sum_model);
                d.at  = acc_at;
                exp_dn.push_back(d);
            end else begin
                for (int j = 0; j < 4; j++) begin
                    wr_t w;
                    w.addr = (4 * load_bytes + j) % 512;
                    w.val  = (int'(b) >> (6 - 2 * j)) & 3;
                    w.at   = acc_at + j;
                    exp_wr.push_back(w);
                end
                load_bytes++;
                sum_model = sum_model + b;
            end
        end else begin
            fail_now("handshake_timeout");
        end
        @(negedge fpga_clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic do_start(input bit with_abort);
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(negedge fpga_clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        load_bytes = 0;
        sum_model  = 8'h00;
        check("busy_after_start",  bus.busy, 1'b1);
        check("error_clear_start", bus.error, 1'b0);
        check("ready_after_start", bus.byte_ready, 1'b1);
        check("addr_after_start",  64'(bus.table_write_addr), 64'd0);
    endtask

    task automatic wait_done();
        #1;
        for (int t = 0; t < 10; t++) begin
            if (exp_dn.size() == 0) break;
            @(negedge fpga_clk);
            #1;
        end
        check("done_seen", 64'(exp_dn.size()), 64'd0);
        check("all_writes_done", 64'(exp_wr.size()), 64'd0);
        exp_dn.delete();
        exp_wr.delete();
        @(negedge fpga_clk);
        check("idle_after_finish", bus.busy, 1'b0);
    endtask

    task automatic run_load(input logic [7:0] chk, input int max_gap, input bit noise, input bit with_abort);
        longint a;
        int gap;
        do_start(with_abort);
        for (int k = 0; k < 128; k++) begin
            send_byte(load_data[k], 1'b0, a);
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                if (noise && $urandom_range(0, 3) == 0) bus.start = 1'b1;
                @(negedge fpga_clk);
                bus.start = 1'b0;
            end
        end
        send_byte(chk, 1'b1, a);
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        longint a;
        int s;

        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        load_bytes     = 0;
        sum_model      = 8'h00;

        // Reset values
        #12;
        check("rst_byte_ready", bus.byte_ready, 1'b0);
        check("rst_table_we",   bus.table_we, 1'b0);
        check("rst_busy",       bus.busy, 1'b0);
        check("rst_done",       bus.done, 1'b0);
        check("rst_error",      bus.error, 1'b0);
        check("rst_table_val",  64'(bus.table_val), 64'd0);
        check("rst_addr",       64'(bus.table_write_addr), 64'd0);
        @(negedge fpga_clk);
        reset_n = 1'b1;

        // Idle ignores byte_valid and abort
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge fpga_clk);
        bus.abort = 1'b1;
        @(negedge fpga_clk);
        bus.abort = 1'b0;
        bus.byte_valid = 1'b0;
        check("idle_busy",  bus.busy, 1'b0);
        check("idle_ready", bus.byte_ready, 1'b0);
        check("idle_error_after_abort", bus.error, 1'b0);

        // Full load 0x00..0x7F with the right checksum
        for (int k = 0; k < 128; k++) load_data[k] = 8'(k);
        run_load(8'hC0, 0, 1'b0, 1'b0);
        check("error_good_load", bus.error, 1'b0);

        // 0xE4 first, abort during the tenth byte's writes
        do_start(1'b0);
        load_data[0] = 8'hE4;
        for (int k = 1; k < 10; k++) load_data[k] = 8'($urandom);
        for (int k = 0; k < 10; k++) send_byte(load_data[k], 1'b0, a);
        @(negedge fpga_clk);
        bus.abort = 1'b1;
        prune_after(a + 1);
        @(negedge fpga_clk);
        bus.abort = 1'b0;
        check("abort_we_low",  bus.table_we, 1'b0);
        check("abort_error",   bus.error, 1'b1);
        check("abort_busy",    bus.busy, 1'b0);
        check("abort_ready",   bus.byte_ready, 1'b0);
        repeat (3) @(negedge fpga_clk);
        #1;
        check("abort_writes_drained", 64'(exp_wr.size()), 64'd0);
        exp_wr.delete();

        // Abort in idle leaves the sticky error alone
        bus.abort = 1'b1;
        @(negedge fpga_clk);
        bus.abort = 1'b0;
        check("idle_abort_error_kept", bus.error, 1'b1);
        check("idle_abort_busy", bus.busy, 1'b0);

        // Bad checksum: all writes still happen, error flagged at done
        for (int k = 0; k < 128; k++) load_data[k] = 8'(k);
        run_load(8'h00, 0, 1'b0, 1'b0);
        check("error_bad_load", bus.error, 1'b1);

        // Random data, gaps, start noise; start+abort in idle starts the load
        s = 0;
        for (int k = 0; k < 128; k++) begin
            load_data[k] = 8'($urandom);
            s = s + int'(load_data[k]);
        end
        run_load(8'(s), 20, 1'b1, 1'b1);
        check("error_random_load", bus.error, 1'b0);

        // Reset while address 37 is on the bus
        do_start(1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'($urandom), 1'b0, a);
        @(negedge fpga_clk);
        #2;
        reset_n = 1'b0;
        prune_after(a + 1);
        #1;
        check("mid_rst_table_we", bus.table_we, 1'b0);
        check("mid_rst_ready",    bus.byte_ready, 1'b0);
        check("mid_rst_busy",     bus.busy, 1'b0);
        check("mid_rst_done",     bus.done, 1'b0);
        check("mid_rst_error",    bus.error, 1'b0);
        check("mid_rst_val",      64'(bus.table_val), 64'd0);
        check("mid_rst_addr",     64'(bus.table_write_addr), 64'd0);
        check("mid_rst_pending",  64'(exp_wr.size()), 64'd0);
        exp_wr.delete();
        repeat (2) @(negedge fpga_clk);
        reset_n = 1'b1;
        bus.byte_valid = 1'b1;
        for (int t = 0; t < 15; t++) begin
            bus.byte_data = 8'($urandom);
            @(negedge fpga_clk);
        end
        bus.byte_valid = 1'b0;
        check("post_rst_idle_busy", bus.busy, 1'b0);

        // Start and abort together while busy: abort wins
        do_start(1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0, a);
        repeat (5) @(negedge fpga_clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge fpga_clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("both_busy_busy",  bus.busy, 1'b0);
        check("both_busy_error", bus.error, 1'b1);
        repeat (3) @(negedge fpga_clk);
        #1;
        check("both_busy_writes_done", 64'(exp_wr.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
